// File: rtl/npc_ras_unit.sv
// Next-PC unit for the 5-stage MIPS pipeline: owns F_PC/D_PC, resolves D-stage
// redirects, exceptions/eret, and predicts jr $ra targets from a circular RAS.
module npc_ras_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        D_valid,
  input  logic [2:0]  D_ctrl,
  input  logic        D_cond,
  input  logic [25:0] D_imm,
  input  logic [31:0] D_rd1,
  input  logic        D_rd1_ready,
  input  logic        D_rs_is_ra,
  input  logic [31:0] E_rs_val,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC8,
  output logic        D_bd,
  output logic        flush_F,
  output logic        jr_stall
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] C_BR   = 3'd1;
  localparam logic [2:0] C_J    = 3'd2;
  localparam logic [2:0] C_JAL  = 3'd3;
  localparam logic [2:0] C_JR   = 3'd4;
  localparam logic [2:0] C_JALR = 3'd5;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_bd_q, d_bd_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_tgt_q, spec_tgt_d;
  logic [RAS_DEPTH-1:0][31:0] ras_q, ras_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [PW-1:0] top_idx;
  logic [31:0]   ras_top, link, br_tgt, j_tgt, jr_tgt;
  logic          is_br, is_jmp, is_jal, is_jr, is_jalr, is_ctl;
  logic          ras_nonempty, d_fire, mispredict, exc_any, hold, push, pop;

  assign is_br   = (D_ctrl == C_BR);
  assign is_jmp  = (D_ctrl == C_J) | (D_ctrl == C_JAL);
  assign is_jal  = (D_ctrl == C_JAL);
  assign is_jr   = (D_ctrl == C_JR);
  assign is_jalr = (D_ctrl == C_JALR);
  assign is_ctl  = is_br | is_jmp | is_jr | is_jalr;

  // ptr_q is the next write slot; the top of stack sits just below it
  assign top_idx      = ptr_q - PW'(1);
  assign ras_top      = ras_q[top_idx];
  assign ras_nonempty = (cnt_q != '0);

  // Only a plain jr $ra can ride a prediction; jalr always waits for rs
  assign jr_stall   = D_valid & (is_jr | is_jalr) & ~D_rd1_ready
                    & ~(D_rs_is_ra & ras_nonempty & is_jr);
  assign exc_any    = exc_req | eret_req;
  assign d_fire     = D_valid & ~stall & ~jr_stall & ~exc_any;
  assign mispredict = spec_q & (E_rs_val != spec_tgt_q);
  assign flush_F    = mispredict & ~exc_any;
  assign hold       = ~exc_any & ~mispredict & (stall | jr_stall);

  assign link   = d_pc_q + 32'd8;
  assign br_tgt = f_pc_q + {{14{D_imm[15]}}, D_imm[15:0], 2'b00};
  assign j_tgt  = {d_pc_q[31:28], D_imm, 2'b00};
  assign jr_tgt = D_rd1_ready ? D_rd1 : ras_top;

  assign F_PC  = f_pc_q;
  assign D_PC8 = link;
  assign D_bd  = d_bd_q;

  always_comb begin
    f_pc_d = f_pc_q + 32'd4;
    if (exc_req)         f_pc_d = HANDLER_PC;
    else if (eret_req)   f_pc_d = epc;
    else if (mispredict) f_pc_d = E_rs_val;
    else if (hold)       f_pc_d = f_pc_q;
    else if (d_fire) begin
      if (is_br && D_cond)        f_pc_d = br_tgt;
      else if (is_jmp)            f_pc_d = j_tgt;
      else if (is_jr || is_jalr)  f_pc_d = jr_tgt;
    end
  end

  always_comb begin
    d_pc_d     = hold ? d_pc_q : f_pc_q;
    d_bd_d     = hold ? d_bd_q : (d_fire & is_ctl);
    spec_d     = d_fire & is_jr & ~D_rd1_ready;
    spec_tgt_d = spec_d ? ras_top : spec_tgt_q;
  end

  // jalr $ra pops then pushes, which nets out to overwriting the top entry
  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    push  = d_fire & (is_jal | is_jalr);
    pop   = d_fire & (is_jr | is_jalr) & D_rs_is_ra & ras_nonempty;
    if (push && pop) begin
      ras_d[top_idx] = link;
    end else if (push) begin
      ras_d[ptr_q] = link;
      ptr_d        = ptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_pc_q     <= RESET_PC;
      d_pc_q     <= RESET_PC - 32'd4;
      d_bd_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_tgt_q <= '0;
      ras_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      f_pc_q     <= f_pc_d;
      d_pc_q     <= d_pc_d;
      d_bd_q     <= d_bd_d;
      spec_q     <= spec_d;
      spec_tgt_q <= spec_tgt_d;
      ras_q      <= ras_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_ras_unit.sv
// Bench for npc_ras_unit: directed vector table, hand-written corner sequences,
// and random stimulus checked against a queue-based reference model.
module tb_npc_ras_unit;
  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, D_valid, D_cond, D_rd1_ready, D_rs_is_ra, exc_req, eret_req;
  logic [2:0]  D_ctrl;
  logic [25:0] D_imm;
  logic [31:0] D_rd1, E_rs_val, epc;
  logic [31:0] F_PC, D_PC8;
  logic        D_bd, flush_F, jr_stall;

  npc_ras_unit #(.RESET_PC(32'h3000), .HANDLER_PC(32'h4180), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .D_valid(D_valid), .D_ctrl(D_ctrl),
    .D_cond(D_cond), .D_imm(D_imm), .D_rd1(D_rd1), .D_rd1_ready(D_rd1_ready),
    .D_rs_is_ra(D_rs_is_ra), .E_rs_val(E_rs_val), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .F_PC(F_PC), .D_PC8(D_PC8), .D_bd(D_bd), .flush_F(flush_F), .jr_stall(jr_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, vl; bit [2:0] c; bit cd; bit [25:0] im; bit [31:0] r1;
    bit rd, ra; bit [31:0] ev; bit ex, er; bit [31:0] ep;
  } vec_t;

  typedef struct {
    vec_t v; bit [31:0] e_fpc; bit e_bd, e_jrs, e_flush;
  } tv_t;

  int n_pass = 0, n_total = 0;

  // Reference model state: architectural PCs plus the RAS as a bounded queue
  logic [31:0] m_fpc, m_dpc, m_tgt;
  bit          m_bd, m_spec;
  logic [31:0] m_ras[$];

  function automatic vec_t mk(bit st, bit vl, bit [2:0] c, bit cd, bit [25:0] im,
                              bit [31:0] r1, bit rd, bit ra, bit [31:0] ev,
                              bit ex, bit er, bit [31:0] ep);
    vec_t v;
    v.st = st; v.vl = vl; v.c = c; v.cd = cd; v.im = im; v.r1 = r1;
    v.rd = rd; v.ra = ra; v.ev = ev; v.ex = ex; v.er = er; v.ep = ep;
    return v;
  endfunction

  function automatic tv_t tv(vec_t v, bit [31:0] fpc, bit bd, bit jrs, bit fl);
    tv_t t;
    t.v = v; t.e_fpc = fpc; t.e_bd = bd; t.e_jrs = jrs; t.e_flush = fl;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_fpc = 32'h3000; m_dpc = 32'h2FFC; m_bd = 0; m_spec = 0; m_tgt = 0;
    m_ras.delete();
  endtask

  task automatic ras_push(input logic [31:0] val);
    m_ras.push_back(val);
    if (m_ras.size() > RAS_DEPTH) m_ras.delete(0);
  endtask

  // Called at posedge+1: drive, check outputs mid-cycle, clock, advance model
  task automatic step(input vec_t v, output bit o_flush, output bit o_jrs);
    int          cnt;
    logic [31:0] top, nf;
    bit          isjr, isjalr, jrs, fire, mis, fl, hold;
    stall = v.st; D_valid = v.vl; D_ctrl = v.c; D_cond = v.cd; D_imm = v.im;
    D_rd1 = v.r1; D_rd1_ready = v.rd; D_rs_is_ra = v.ra; E_rs_val = v.ev;
    exc_req = v.ex; eret_req = v.er; epc = v.ep;
    #2;
    cnt    = m_ras.size();
    top    = (cnt > 0) ? m_ras[cnt-1] : 32'h0;
    isjr   = (v.c == 3'd4);
    isjalr = (v.c == 3'd5);
    jrs    = v.vl && (isjr || isjalr) && !v.rd && !(v.ra && cnt > 0 && isjr);
    fire   = v.vl && !v.st && !jrs && !v.ex && !v.er;
    mis    = m_spec && (v.ev != m_tgt);
    fl     = mis && !v.ex && !v.er;
    o_flush = flush_F; o_jrs = jr_stall;
    chk("jr_stall", 32'(jr_stall), 32'(jrs));
    chk("flush_F",  32'(flush_F),  32'(fl));
    chk("F_PC",     F_PC,          m_fpc);
    chk("D_PC8",    D_PC8,         m_dpc + 32'd8);
    chk("D_bd",     32'(D_bd),     32'(m_bd));
    hold = !v.ex && !v.er && !mis && (v.st || jrs);
    nf = m_fpc + 32'd4;
    if (v.ex)       nf = 32'h4180;
    else if (v.er)  nf = v.ep;
    else if (mis)   nf = v.ev;
    else if (hold)  nf = m_fpc;
    else if (fire) begin
      case (v.c)
        3'd1:       if (v.cd) nf = m_fpc + 32'($signed(v.im[15:0])) * 4;
        3'd2, 3'd3: nf = (m_dpc & 32'hF000_0000) | (32'(v.im) * 4);
        3'd4, 3'd5: nf = v.rd ? v.r1 : top;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    if (fire) begin
      if (v.c == 3'd3) ras_push(m_dpc + 8);
      if (isjalr) begin
        if (v.ra && cnt > 0) void'(m_ras.pop_back());
        ras_push(m_dpc + 8);
      end
      if (isjr && v.ra && cnt > 0) void'(m_ras.pop_back());
    end
    m_spec = fire && isjr && !v.rd;
    if (m_spec) m_tgt = top;
    if (!hold) begin
      m_bd  = fire && v.c >= 3'd1 && v.c <= 3'd5;
      m_dpc = m_fpc;
    end
    m_fpc = nf;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  vec_t idle;
  tv_t  tbl[16];
  bit   f, j;
  logic [31:0] exp_pop[4];
  logic [31:0] prev;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0);
    tbl[0]  = tv(idle,                                            32'h3004, 0, 0, 0);
    tbl[1]  = tv(idle,                                            32'h3008, 0, 0, 0);
    tbl[2]  = tv(mk(0,1,1,1,26'h3,0,0,0,0,0,0,0),                 32'h3014, 1, 0, 0);
    tbl[3]  = tv(mk(0,1,1,0,26'h3,0,0,0,0,0,0,0),                 32'h3018, 1, 0, 0);
    tbl[4]  = tv(mk(0,1,2,0,26'h400,0,0,0,0,0,0,0),               32'h1000, 1, 0, 0);
    tbl[5]  = tv(idle,                                            32'h1004, 0, 0, 0);
    tbl[6]  = tv(mk(1,1,2,0,26'h400,0,0,0,0,0,0,0),               32'h1004, 0, 0, 0);
    tbl[7]  = tv(mk(0,1,3,0,26'h800,0,0,0,0,0,0,0),               32'h2000, 1, 0, 0);
    tbl[8]  = tv(mk(0,1,4,0,0,0,0,1,0,0,0,0),                     32'h1008, 1, 0, 0);
    tbl[9]  = tv(mk(0,0,0,0,0,0,0,0,32'h1008,0,0,0),              32'h100C, 0, 0, 0);
    tbl[10] = tv(mk(0,1,4,0,0,0,0,1,0,0,0,0),                     32'h100C, 0, 1, 0);
    tbl[11] = tv(mk(0,1,4,0,0,32'h5000,1,1,0,0,0,0),              32'h5000, 1, 0, 0);
    tbl[12] = tv(mk(0,1,1,1,26'h3,0,0,0,0,1,0,0),                 32'h4180, 0, 0, 0);
    tbl[13] = tv(mk(0,0,0,0,0,0,0,0,0,0,1,32'h3ABC),              32'h3ABC, 0, 0, 0);
    tbl[14] = tv(mk(0,1,5,0,0,0,0,1,0,0,0,0),                     32'h3ABC, 0, 1, 0);
    tbl[15] = tv(mk(0,1,6,0,0,0,0,0,0,0,0,0),                     32'h3AC0, 0, 0, 0);

    stall = 0; D_valid = 0; D_ctrl = 0; D_cond = 0; D_imm = 0; D_rd1 = 0;
    D_rd1_ready = 0; D_rs_is_ra = 0; E_rs_val = 0; exc_req = 0; eret_req = 0; epc = 0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset F_PC",  F_PC,        32'h3000);
    chk("reset D_PC8", D_PC8,       32'h3004);
    chk("reset D_bd",  32'(D_bd),   32'h0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, f, j);
      chk($sformatf("tbl%0d F_PC", i),     F_PC,       tbl[i].e_fpc);
      chk($sformatf("tbl%0d D_bd", i),     32'(D_bd),  32'(tbl[i].e_bd));
      chk($sformatf("tbl%0d jr_stall", i), 32'(j),     32'(tbl[i].e_jrs));
      chk($sformatf("tbl%0d flush_F", i),  32'(f),     32'(tbl[i].e_flush));
    end

    // Mispredicted jr $ra: one flush cycle, then redirect to the real rs
    do_reset();
    step(mk(0,1,3,0,26'hC40,0,0,0,0,0,0,0), f, j);
    step(mk(0,1,4,0,0,0,0,1,0,0,0,0), f, j);
    chk("misp predicted F_PC", F_PC, 32'h3004);
    step(mk(0,0,0,0,0,0,0,0,32'h3400,0,0,0), f, j);
    chk("misp flush_F", 32'(f), 32'h1);
    chk("misp F_PC", F_PC, 32'h3400);
    step(mk(0,0,0,0,0,0,0,0,32'h3400,0,0,0), f, j);
    chk("misp flush cleared", 32'(f), 32'h0);
    chk("misp F_PC+4", F_PC, 32'h3404);

    // RAS overflow: five pushes into four entries, then pop newest-first
    do_reset();
    for (int k = 0; k < 5; k++)
      step(mk(0,1,3,0,26'((32'h3100 + 32'h100 * k) >> 2),0,0,0,0,0,0,0), f, j);
    exp_pop[0] = 32'h3308; exp_pop[1] = 32'h3208; exp_pop[2] = 32'h3108; exp_pop[3] = 32'h3008;
    prev = 32'h0;
    for (int k = 0; k < 4; k++) begin
      step(mk(0,1,4,0,0,0,0,1,prev,0,0,0), f, j);
      chk($sformatf("ras pop%0d F_PC", k), F_PC, exp_pop[k]);
      chk($sformatf("ras pop%0d flush_F", k), 32'(f), 32'h0);
      prev = exp_pop[k];
    end
    step(mk(0,1,4,0,0,0,0,1,prev,0,0,0), f, j);
    chk("ras empty jr_stall", 32'(j), 32'h1);
    chk("ras empty F_PC hold", F_PC, 32'h3008);

    // Exception beats stall and masks a pending mispredict
    do_reset();
    step(mk(0,1,3,0,26'hC40,0,0,0,0,0,0,0), f, j);
    step(mk(0,1,4,0,0,0,0,1,0,0,0,0), f, j);
    chk("prio pre D_bd", 32'(D_bd), 32'h1);
    step(mk(1,1,0,0,0,0,0,0,32'h9999,1,0,0), f, j);
    chk("prio flush_F", 32'(f), 32'h0);
    chk("prio F_PC", F_PC, 32'h4180);
    chk("prio D_bd", 32'(D_bd), 32'h0);
    step(mk(0,0,0,0,0,0,0,0,32'h9999,0,0,0), f, j);
    chk("prio spec cleared", 32'(f), 32'h0);
    chk("prio F_PC+4", F_PC, 32'h4184);

    // Random traffic against the model, with one asynchronous reset mid-run
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v.st = ($urandom_range(0, 4) == 0);
      v.vl = ($urandom_range(0, 5) != 0);
      v.c  = 3'($urandom_range(0, 7));
      v.cd = 1'($urandom);
      v.im = 26'($urandom);
      v.r1 = $urandom;
      v.rd = 1'($urandom);
      v.ra = ($urandom_range(0, 9) < 6);
      v.ev = (m_spec && $urandom_range(0, 3) != 0) ? m_tgt : $urandom;
      v.ex = ($urandom_range(0, 49) == 0);
      v.er = ($urandom_range(0, 49) == 0);
      v.ep = $urandom;
      step(v, f, j);
      if (i == 1500) begin
        reset_n = 1'b0;
        #1;
        chk("async reset F_PC",  F_PC,      32'h3000);
        chk("async reset D_PC8", D_PC8,     32'h3004);
        chk("async reset D_bd",  32'(D_bd), 32'h0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
